lloyds_block_scheduler: RTL

// Synthesizable controller that sequences the Lloyd's/filtering HLS kernels over a point set, replacing

---
 rtl/lloyds_block_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/lloyds_block_scheduler.sv
// Sequences init kernel then round-robin block kernels over N points for NUM_ITER passes; ap_ctrl_hs on all kernels.
// Issue one cycle after a channel is seen FREE; ap_start held until ap_ready, dispatch stalls while no channel is free.
module lloyds_block_scheduler #(
    parameter int B  = 16,
    parameter int D  = 3,
    parameter int P  = 2,
    parameter int NW = 32,
    parameter int IW = 8
) (
    input  logic            clk_in1,
    input  logic            reset,
    input  logic            start,
    input  logic [NW-1:0]   n_points,
    input  logic [IW-1:0]   num_iter,
    output logic            init_ap_start,
    input  logic            init_ap_ready,
    input  logic            init_ap_done,
    output logic [P-1:0]    blk_ap_start,
    input  logic [P-1:0]    blk_ap_ready,
    input  logic [P-1:0]    blk_ap_done,
    output logic [P*NW-1:0] blk_address,
    output logic [P*NW-1:0] blk_len,
    output logic            iter_done,
    output logic            busy,
    output logic            done,
    output logic [NW-1:0]   cycle_count
);

    localparam int IDXW = (P > 1) ? $clog2(P) : 1;
    localparam logic [NW-1:0] BLK    = NW'(B);
    localparam logic [NW-1:0] STRIDE = NW'(B * D);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_INIT_WAIT, S_DISPATCH, S_DRAIN, S_ITER_END, S_DONE
    } state_t;

    typedef enum logic [1:0] {CH_FREE, CH_STARTING, CH_RUNNING} ch_t;

    state_t          state;
    ch_t             ch_state [P];
    logic [NW-1:0]   n_pts;
    logic [NW-1:0]   remaining;
    logic [NW-1:0]   next_addr;
    logic [IW-1:0]   iters_left;

    logic            free_found;
    logic [IDXW-1:0] free_idx;
    logic            all_free;
    logic [NW-1:0]   issue_len;
    logic            go_run;
    logic            init_finish;

    // Descending scan so the lowest-index FREE channel wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        all_free   = 1'b1;
        for (int c = P - 1; c >= 0; c--) begin
            if (ch_state[c] == CH_FREE) begin
                free_found = 1'b1;
                free_idx   = IDXW'(c);
            end else begin
                all_free = 1'b0;
            end
        end
        issue_len   = (remaining < BLK) ? remaining : BLK;
        go_run      = (n_pts != '0) && (iters_left != '0);
        // A kernel may raise ap_ready and ap_done together while still in INIT.
        init_finish = init_ap_done && ((state == S_INIT_WAIT) || (state == S_INIT && init_ap_ready));
    end

    always_ff @(posedge clk_in1) begin
        if (reset) begin
            state         <= S_IDLE;
            init_ap_start <= 1'b0;
            blk_ap_start  <= '0;
            blk_address   <= '0;
            blk_len       <= '0;
            iter_done     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cycle_count   <= '0;
            n_pts         <= '0;
            remaining     <= '0;
            next_addr     <= '0;
            iters_left    <= '0;
            for (int c = 0; c < P; c++) ch_state[c] <= CH_FREE;
        end else begin
            for (int c = 0; c < P; c++) begin
                case (ch_state[c])
                    CH_STARTING: if (blk_ap_ready[c]) begin
                        blk_ap_start[c] <= 1'b0;
                        ch_state[c]     <= blk_ap_done[c] ? CH_FREE : CH_RUNNING;
                    end
                    CH_RUNNING: if (blk_ap_done[c]) ch_state[c] <= CH_FREE;
                    default: ;
                endcase
            end

            if (state == S_IDLE) begin
                if (start) cycle_count <= '0;
            end else if (cycle_count != '1) begin
                cycle_count <= cycle_count + NW'(1);
            end

            case (state)
                S_IDLE: if (start) begin
                    state         <= S_INIT;
                    busy          <= 1'b1;
                    init_ap_start <= 1'b1;
                    n_pts         <= n_points;
                    iters_left    <= num_iter;
                end
                S_INIT, S_INIT_WAIT: begin
                    if (state == S_INIT && init_ap_ready) init_ap_start <= 1'b0;
                    if (init_finish) begin
                        state     <= go_run ? S_DISPATCH : S_DONE;
                        done      <= !go_run;
                        remaining <= n_pts;
                        next_addr <= '0;
                    end else if (state == S_INIT && init_ap_ready) begin
                        state <= S_INIT_WAIT;
                    end
                end
                S_DISPATCH: if (free_found) begin
                    blk_ap_start[free_idx]                   <= 1'b1;
                    ch_state[free_idx]                       <= CH_STARTING;
                    blk_address[int'(free_idx) * NW +: NW]   <= next_addr;
                    blk_len[int'(free_idx) * NW +: NW]       <= issue_len;
                    next_addr                                <= next_addr + STRIDE;
                    remaining                                <= remaining - issue_len;
                    if (remaining == issue_len) state <= S_DRAIN;
                end
                S_DRAIN: if (all_free) begin
                    state     <= S_ITER_END;
                    iter_done <= 1'b1;
                end
                S_ITER_END: begin
                    iter_done <= 1'b0;
                    if (iters_left == IW'(1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        iters_left <= iters_left - IW'(1);
                        remaining  <= n_pts;
                        next_addr  <= '0;
                        state      <= S_DISPATCH;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
